prog_freq_serial_out: RTL and testbench



---
 rtl/serial_out_pkg.sv | 30 +++
 rtl/prog_tick_gen.sv | 38 +++
 rtl/prog_freq_serial_out.sv | 145 ++++++++++++++
 tb/tb_prog_freq_serial_out.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_out_pkg.sv
// ============================================================================
//  Module   : serial_out_pkg
//  Brief    : Shared FSM encoding, mode constants and frame-length helper for
//             prog_freq_serial_out. Honours macro SERIAL_OUT_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_out_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_REPEAT  = 1'b1;

    // Number of serial bits per frame, including the optional parity bit.
    function automatic int frame_len(input int data_bit);
`ifdef SERIAL_OUT_PARITY_EN
        return data_bit + 1;
`else
        return data_bit;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_tick_gen.sv
// ============================================================================
//  Module   : prog_tick_gen
//  Brief    : Programmable mod-D prescaler, D = max(divisor, 1); tick marks
//             the last clock of each period.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_tick_gen #(
    parameter int DIV_BIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [DIV_BIT-1:0] divisor,
    output logic               tick
);

    logic [DIV_BIT-1:0] r_count;
    logic [DIV_BIT-1:0] w_last;

    // Divisor 0 behaves like 1; >= keeps the counter bounded if D shrinks.
    assign w_last = (divisor == '0) ? '0 : (divisor - DIV_BIT'(1));
    assign tick   = (r_count >= w_last);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + DIV_BIT'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_freq_serial_out.sv
// ============================================================================
//  Module   : prog_freq_serial_out
//  Brief    : LSB-first serial output engine with runtime-programmable bit
//             rate, one-shot/repeat modes and abort. Optional even-parity bit
//             enabled by macro SERIAL_OUT_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_freq_serial_out
    import serial_out_pkg::*;
#(
    parameter int DATA_BIT     = 32,
    parameter int DIV_BIT      = 16,
    parameter int TICK_PER_BIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_mode,
    input  logic [DIV_BIT-1:0]  i_divisor,
    input  logic [DATA_BIT-1:0] i_data,
    output logic                o_bit_tick,
    output logic                o_data,
    output logic                o_done_tick,
    output logic                o_busy
);

    localparam int FRAME_LEN = frame_len(DATA_BIT);
    localparam int TICK_W    = (TICK_PER_BIT > 1) ? $clog2(TICK_PER_BIT) : 1;
    localparam int BIT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(FRAME_LEN - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_load;
    logic                   w_tick;
    logic                   w_clear;
    logic                   w_bit_last_tick;
    logic                   w_frame_end;
    logic [FRAME_LEN-1:0]   w_load_word;
    logic [FRAME_LEN-1:0]   r_shift;
    logic [DIV_BIT-1:0]     r_divisor;
    logic                   r_mode;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;

`ifdef SERIAL_OUT_PARITY_EN
    assign w_load_word = {^i_data, i_data};
`else
    assign w_load_word = i_data;
`endif

    assign w_bit_last_tick = (r_state == ST_RUN) && w_tick && (r_tick_cnt == C_TICK_LAST);
    assign w_frame_end     = w_bit_last_tick && (r_bit_cnt == C_BIT_LAST);

    // Prescaler restarts on every word load and is held while idle.
    assign w_clear = w_load || (w_state_next == ST_IDLE);

    prog_tick_gen #(
        .DIV_BIT (DIV_BIT)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .divisor (r_divisor),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        o_busy       = 1'b0;
        o_data       = 1'b0;
        o_bit_tick   = 1'b0;
        o_done_tick  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_next = ST_RUN;
                    w_load       = 1'b1;
                end
            end
            ST_RUN: begin
                o_busy     = 1'b1;
                o_data     = r_shift[0];
                o_bit_tick = w_bit_last_tick;
                if (i_stop) begin
                    w_state_next = ST_IDLE;
                end else if (w_frame_end) begin
                    o_done_tick = 1'b1;
                    if (r_mode == MODE_REPEAT) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_divisor  <= '0;
            r_mode     <= MODE_ONESHOT;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_load) begin
            r_shift    <= w_load_word;
            r_divisor  <= i_divisor;
            r_mode     <= i_mode;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_state_next == ST_IDLE) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_tick) begin
            if (r_tick_cnt == C_TICK_LAST) begin
                r_tick_cnt <= '0;
                r_shift    <= {1'b0, r_shift[FRAME_LEN-1:1]};
                r_bit_cnt  <= (r_bit_cnt == C_BIT_LAST) ? '0 : (r_bit_cnt + BIT_W'(1));
            end else begin
                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_freq_serial_out.sv
// ============================================================================
//  Module   : tb_prog_freq_serial_out
//  Brief    : Self-checking bench for prog_freq_serial_out (DATA_BIT=8,
//             TICK_PER_BIT=4), expected waveform queued per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_freq_serial_out;

    localparam int DB  = 8;
    localparam int DVB = 16;
    localparam int TPB = 4;
`ifdef SERIAL_OUT_PARITY_EN
    localparam int FL = DB + 1;
`else
    localparam int FL = DB;
`endif

    typedef struct packed {
        logic busy;
        logic data;
        logic bt;
        logic dt;
    } obs_t;

    typedef struct {
        logic [DVB-1:0] div;
        logic [DB-1:0]  data;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_start = 1'b0;
    logic           i_stop = 1'b0;
    logic           i_mode = 1'b0;
    logic [DVB-1:0] i_divisor = '0;
    logic [DB-1:0]  i_data = '0;
    logic           o_bit_tick;
    logic           o_data;
    logic           o_done_tick;
    logic           o_busy;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    prog_freq_serial_out #(
        .DATA_BIT     (DB),
        .DIV_BIT      (DVB),
        .TICK_PER_BIT (TPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_mode      (i_mode),
        .i_divisor   (i_divisor),
        .i_data      (i_data),
        .o_bit_tick  (o_bit_tick),
        .o_data      (o_data),
        .o_done_tick (o_done_tick),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    function automatic int period(input logic [DVB-1:0] d);
        return ((d == '0) ? 1 : int'(d)) * TPB;
    endfunction

    // Expected waveform of one frame: bit k held for P clocks, ticks on the last.
    task automatic push_frame(input logic [DVB-1:0] d, input logic [DB-1:0] w);
        int   p;
        logic b;
        obs_t e;
        p = period(d);
        for (int k = 0; k < FL; k++) begin
            if (k < DB) b = w[k];
            else        b = ^w;
            for (int c = 1; c <= p; c++) begin
                e.busy = 1'b1;
                e.data = b;
                e.bt   = (c == p);
                e.dt   = (c == p) && (k == FL - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step(input string nm, input logic r, input logic st, input logic sp,
                        input logic md, input logic [DVB-1:0] d, input logic [DB-1:0] w);
        obs_t e;
        obs_t a;
        @(posedge clk);
        #1;
        rst = r; i_start = st; i_stop = sp; i_mode = md; i_divisor = d; i_data = w;
        #1;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        a = {o_busy, o_data, o_bit_tick, o_done_tick};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cyc=%0d busy/data/bit_tick/done_tick got=%b want=%b", nm, cyc, a, e);
        end
        cyc++;
    endtask

    task automatic idle_steps(input string nm, input int n);
        for (int i = 0; i < n; i++) step(nm, 1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), 8'($urandom));
    endtask

    // One-shot frame; inputs other than stop are scrambled while running.
    task automatic run_oneshot(input string nm, input logic [DVB-1:0] d, input logic [DB-1:0] w);
        int n;
        n   = FL * period(d);
        cyc = 0;
        step(nm, 1'b0, 1'b1, 1'b0, 1'b0, d, w);
        push_frame(d, w);
        for (int i = 1; i < n; i++)
            step(nm, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                 16'($urandom), 8'($urandom));
        step({nm, "_done"}, 1'b0, 1'b0, 1'b0, 1'b1, 16'($urandom), 8'($urandom));
        idle_steps({nm, "_idle"}, 3);
    endtask

    vec_t vt[8];
    int   abort_at[2];

    initial begin
        vt[0] = '{16'd3, 8'hA5};
        vt[1] = '{16'd0, 8'hA5};
        vt[2] = '{16'd1, 8'hA5};
        vt[3] = '{16'd2, 8'h3C};
        vt[4] = '{16'd5, 8'h81};
        vt[5] = '{16'd0, 8'hFF};
        vt[6] = '{16'd4, 8'h00};
        vt[7] = '{16'd3, 8'h07};
        abort_at[0] = 30;
        abort_at[1] = 24;

        cyc = 0;
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 8'hA5);
        idle_steps("post_reset", 2);

        for (int v = 0; v < 8; v++) run_oneshot("oneshot", vt[v].div, vt[v].data);

        // Repeat: word 2 re-latched at the first done, with new divisor and mode=0.
        begin
            int n1;
            int n2;
            n1  = FL * period(16'd2);
            n2  = FL * period(16'd1);
            cyc = 0;
            step("repeat", 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 8'h0F);
            push_frame(16'd2, 8'h0F);
            push_frame(16'd1, 8'hF0);
            for (int i = 1; i < n1; i++) step("repeat_w1", 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 8'hF0);
            step("repeat_done1", 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 8'hF0);
            for (int i = 1; i < n2; i++)
                step("repeat_w2", 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                     16'($urandom), 8'($urandom));
            step("repeat_done2", 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 8'h55);
            idle_steps("repeat_idle", 3);
        end

        // Abort mid-bit and on a bit-tick cycle.
        for (int a = 0; a < 2; a++) begin
            cyc = 0;
            step("abort", 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 8'hA5);
            push_frame(16'd3, 8'hA5);
            for (int i = 1; i < abort_at[a]; i++) step("abort_run", 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 8'hA5);
            step("abort_stop", 1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 8'hA5);
            exp_q.delete();
            idle_steps("abort_idle", 4);
        end

        cyc = 0;
        step("start_and_stop", 1'b0, 1'b1, 1'b1, 1'b0, 16'd3, 8'hA5);
        idle_steps("start_and_stop_idle", 3);

        // Reset mid-frame, then a clean one-shot.
        cyc = 0;
        step("rst_mid", 1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 8'hA5);
        push_frame(16'd3, 8'hA5);
        for (int i = 1; i < 50; i++) step("rst_mid_run", 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 8'hA5);
        step("rst_mid_assert", 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 8'hA5);
        exp_q.delete();
        idle_steps("rst_mid_after", 3);
        run_oneshot("after_reset", 16'd3, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
